// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - oldest-first issue select and round-robin dispatch allocation for an RS bank
//
// Optional build macro: RS_SCHED_PERF_EN (adds perf_issue_cnt / perf_full_cnt)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pipe_flush          squash: no issue/dispatch this cycle, internal state cleared
//   rs_wake_up          per entry, one-hot FU the entry is ready for (or 0)
//   rs_issued           entry already issued, excluded from select
//   rs_avail            entry free for dispatch
//   rs_age, rob_head    per-entry ROB tag and ROB head tag for age ordering
//   fu_stall            FU cannot accept this cycle
//   dispatch_req        dispatch stage has a packet for this bank
//   issue_en            per-entry issue grant
//   fu_issue_valid      per-FU grant valid
//   fu_issue_idx        per-FU granted entry index
//   dispatch_sel        one-hot entry receiving the dispatch packet
//   dispatch_ok         a free entry exists and dispatch is accepted
//   perf_issue_cnt      (RS_SCHED_PERF_EN) per-FU issue counters, 32 bits each
//   perf_full_cnt       (RS_SCHED_PERF_EN) count of cycles a dispatch was refused

module rs_issue_sched #(
  parameter int NUM_RS      = 8,
  parameter int NUM_FU      = 4,
  parameter int AGE_W       = 6,
  parameter int MULTI_FU_ID = 3,
  parameter int MULTI_LAT   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pipe_flush,
  input  logic [NUM_RS*NUM_FU-1:0]          rs_wake_up,
  input  logic [NUM_RS-1:0]                 rs_issued,
  input  logic [NUM_RS-1:0]                 rs_avail,
  input  logic [NUM_RS*AGE_W-1:0]           rs_age,
  input  logic [AGE_W-1:0]                  rob_head,
  input  logic [NUM_FU-1:0]                 fu_stall,
  input  logic                              dispatch_req,
  output logic [NUM_RS-1:0]                 issue_en,
  output logic [NUM_FU-1:0]                 fu_issue_valid,
  output logic [NUM_FU*$clog2(NUM_RS)-1:0]  fu_issue_idx,
  output logic [NUM_RS-1:0]                 dispatch_sel,
`ifdef RS_SCHED_PERF_EN
  output logic [NUM_FU*32-1:0]              perf_issue_cnt,
  output logic [31:0]                       perf_full_cnt,
`endif
  output logic                              dispatch_ok
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

  logic [CNT_W-1:0] busy_cnt;
  logic [IDX_W-1:0] rr_ptr;

  logic [AGE_W-1:0] rel [NUM_RS];
  logic [NUM_FU-1:0] fu_open;
  logic [NUM_FU-1:0] grant_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              dispatch_fire;

  // Distance from the ROB head; modular subtraction makes wrapped tags order correctly.
  always_comb begin
    for (int e = 0; e < NUM_RS; e++) begin
      rel[e] = rs_age[e*AGE_W +: AGE_W] - rob_head;
    end
  end

  // An FU can take a grant only outside reset/flush, when not stalled, and
  // (for the non-pipelined FU) when its occupancy counter has drained.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_open[f] = rst_n && !pipe_flush && !fu_stall[f] &&
                   !((f == MULTI_FU_ID) && (busy_cnt != '0));
    end
  end

  // Per-FU oldest-first select; strict less-than keeps the lower index on ties.
  always_comb begin : issue_select
    logic             found;
    logic [AGE_W-1:0] best_rel;
    logic [IDX_W-1:0] best_idx;
    grant_valid  = '0;
    issue_en     = '0;
    fu_issue_idx = '0;
    found        = 1'b0;
    best_rel     = '0;
    best_idx     = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      found    = 1'b0;
      best_rel = '0;
      best_idx = '0;
      for (int e = 0; e < NUM_RS; e++) begin
        if (fu_open[f] && rs_wake_up[e*NUM_FU + f] && !rs_issued[e] &&
            (!found || (rel[e] < best_rel))) begin
          found    = 1'b1;
          best_rel = rel[e];
          best_idx = IDX_W'(e);
        end
      end
      grant_valid[f] = found;
      if (found) begin
        fu_issue_idx[f*IDX_W +: IDX_W] = best_idx;
        issue_en[best_idx]             = 1'b1;
      end
    end
  end

  assign fu_issue_valid = grant_valid;

  // Dispatch allocation: first available entry at or after rr_ptr, circularly.
  assign dispatch_ok = rst_n && (|rs_avail) && !pipe_flush;

  always_comb begin : alloc_select
    logic [IDX_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = rr_ptr + IDX_W'(k);
      if (!sel_found && rs_avail[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
    dispatch_fire = dispatch_req && dispatch_ok && sel_found;
    dispatch_sel  = '0;
    if (dispatch_fire) begin
      dispatch_sel[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      rr_ptr   <= '0;
    end else if (pipe_flush) begin
      busy_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      // A grant is only possible with busy_cnt == 0, so load and decrement never collide.
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 1'b1;
      end else if (grant_valid[MULTI_FU_ID] && (MULTI_LAT > 1)) begin
        busy_cnt <= CNT_W'(MULTI_LAT - 1);
      end
      if (dispatch_fire) begin
        rr_ptr <= sel_idx + 1'b1;
      end
    end
  end

`ifdef RS_SCHED_PERF_EN
  // Free-running event counters; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (grant_valid[f]) begin
          perf_issue_cnt[f*32 +: 32] <= perf_issue_cnt[f*32 +: 32] + 32'd1;
        end
      end
      if (dispatch_req && !dispatch_ok) begin
        perf_full_cnt <= perf_full_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - self-checking bench for rs_issue_sched

module tb_rs_issue_sched;

  localparam int NUM_RS      = 8;
  localparam int NUM_FU      = 4;
  localparam int AGE_W       = 6;
  localparam int MULTI_FU_ID = 3;
  localparam int MULTI_LAT   = 4;
  localparam int IDX_W       = $clog2(NUM_RS);
  localparam int AGE_MOD     = 1 << AGE_W;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        pipe_flush = 1'b0;
  logic [NUM_RS*NUM_FU-1:0]    rs_wake_up = '0;
  logic [NUM_RS-1:0]           rs_issued = '0;
  logic [NUM_RS-1:0]           rs_avail = '0;
  logic [NUM_RS*AGE_W-1:0]     rs_age = '0;
  logic [AGE_W-1:0]            rob_head = '0;
  logic [NUM_FU-1:0]           fu_stall = '0;
  logic                        dispatch_req = 1'b0;
  logic [NUM_RS-1:0]           issue_en;
  logic [NUM_FU-1:0]           fu_issue_valid;
  logic [NUM_FU*IDX_W-1:0]     fu_issue_idx;
  logic [NUM_RS-1:0]           dispatch_sel;
  logic                        dispatch_ok;

  rs_issue_sched #(
    .NUM_RS(NUM_RS), .NUM_FU(NUM_FU), .AGE_W(AGE_W),
    .MULTI_FU_ID(MULTI_FU_ID), .MULTI_LAT(MULTI_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .rs_wake_up(rs_wake_up), .rs_issued(rs_issued), .rs_avail(rs_avail),
    .rs_age(rs_age), .rob_head(rob_head), .fu_stall(fu_stall),
    .dispatch_req(dispatch_req), .issue_en(issue_en),
    .fu_issue_valid(fu_issue_valid), .fu_issue_idx(fu_issue_idx),
    .dispatch_sel(dispatch_sel), .dispatch_ok(dispatch_ok)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and expected outputs
  int                      m_busy = 0;
  int                      m_rr   = 0;
  int                      m_sel_idx;
  logic [NUM_RS-1:0]       e_issue;
  logic [NUM_FU-1:0]       e_valid;
  logic [NUM_FU*IDX_W-1:0] e_idx;
  logic [NUM_RS-1:0]       e_sel;
  logic                    e_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int age_rel(input int e);
    return (int'(rs_age[e*AGE_W +: AGE_W]) - int'(rob_head) + AGE_MOD) % AGE_MOD;
  endfunction

  // Expected outputs: for each FU, walk distances 0,1,2,... and take the
  // first eligible entry (lowest index) at the smallest distance.
  task automatic model_eval();
    bit done;
    e_issue = '0; e_valid = '0; e_idx = '0; e_sel = '0; e_ok = 1'b0;
    m_sel_idx = 0;
    if (!rst_n) return;
    for (int f = 0; f < NUM_FU; f++) begin
      if (pipe_flush || fu_stall[f] || (f == MULTI_FU_ID && m_busy != 0)) continue;
      done = 0;
      for (int r = 0; r < AGE_MOD && !done; r++) begin
        for (int e = 0; e < NUM_RS && !done; e++) begin
          if (rs_wake_up[e*NUM_FU + f] && !rs_issued[e] && age_rel(e) == r) begin
            done = 1;
            e_valid[f] = 1'b1;
            e_idx[f*IDX_W +: IDX_W] = IDX_W'(e);
            e_issue[e] = 1'b1;
          end
        end
      end
    end
    e_ok = (rs_avail != '0) && !pipe_flush;
    if (dispatch_req && e_ok) begin
      done = 0;
      for (int k = 0; k < NUM_RS && !done; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_RS;
        if (rs_avail[idx]) begin
          done = 1;
          e_sel[idx] = 1'b1;
          m_sel_idx = idx;
        end
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n || pipe_flush) begin
      m_busy = 0;
      m_rr   = 0;
    end else begin
      if (m_busy > 0) m_busy = m_busy - 1;
      else if (e_valid[MULTI_FU_ID] && MULTI_LAT > 1) m_busy = MULTI_LAT - 1;
      if (dispatch_req && e_ok) m_rr = (m_sel_idx + 1) % NUM_RS;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic sample();
    #1;
    model_eval();
    chk("issue_en", issue_en, e_issue);
    chk("fu_issue_valid", fu_issue_valid, e_valid);
    chk("fu_issue_idx", fu_issue_idx, e_idx);
    chk("dispatch_sel", dispatch_sel, e_sel);
    chk("dispatch_ok", dispatch_ok, e_ok);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    pipe_flush = 0; rs_wake_up = '0; rs_issued = '0; rs_avail = '0;
    rs_age = '0; rob_head = '0; fu_stall = '0; dispatch_req = 0;
  endtask

  task automatic wake(input int e, input int f);
    rs_wake_up[e*NUM_FU + f] = 1'b1;
  endtask

  task automatic set_age(input int e, input int a);
    rs_age[e*AGE_W +: AGE_W] = AGE_W'(a);
  endtask

  initial begin
    // Reset state: outputs held at 0 even with live inputs
    rs_wake_up = '1; rs_avail = '1; dispatch_req = 1;
    #2;
    chk("rst_issue_en", issue_en, 0);
    chk("rst_dispatch_ok", dispatch_ok, 0);
    chk("rst_dispatch_sel", dispatch_sel, 0);
    @(negedge clk);
    clr();
    rst_n = 1;
    tick();

    // Age select with ROB wrap
    rob_head = 60; set_age(2, 62); set_age(5, 1);
    wake(2, 0); wake(5, 0);
    sample();
    chk("wrap_issue_en", issue_en, 8'b0000_0100);
    chk("wrap_idx0", fu_issue_idx[IDX_W-1:0], 2);
    tick();
    rs_wake_up[2*NUM_FU + 0] = 1'b0;
    sample();
    chk("wrap_next_issue_en", issue_en, 8'b0010_0000);
    tick();

    // Parallel FUs
    clr(); wake(0, 1); wake(7, 2);
    sample();
    chk("par_issue_en", issue_en, 8'b1000_0001);
    chk("par_valid", fu_issue_valid, 4'b0110);
    tick();

    // Multi-cycle FU
    clr(); set_age(3, 10); set_age(4, 11); wake(3, 3); wake(4, 3);
    sample();
    chk("mc_t0", issue_en, 8'b0000_1000);
    tick();
    rs_issued[3] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      sample();
      chk("mc_busy_noissue", fu_issue_valid[3], 0);
      tick();
    end
    sample();
    chk("mc_t4", issue_en, 8'b0001_0000);
    tick();
    clr();
    for (int c = 0; c < 4; c++) begin sample(); tick(); end
    set_age(3, 10); set_age(4, 11); wake(3, 3); wake(4, 3);
    sample();
    chk("mcf_t0", issue_en, 8'b0000_1000);
    tick();
    rs_issued[3] = 1'b1; pipe_flush = 1;
    sample();
    chk("mcf_flush_cycle", issue_en, 0);
    tick();
    pipe_flush = 0;
    sample();
    chk("mcf_t2", issue_en, 8'b0001_0000);
    tick();

    // Dispatch round-robin then full
    clr(); rs_avail = 8'hFF; dispatch_req = 1;
    sample(); chk("rr_sel0", dispatch_sel, 8'h01); tick();
    sample(); chk("rr_sel1", dispatch_sel, 8'h02); tick();
    sample(); chk("rr_sel2", dispatch_sel, 8'h04); tick();
    rs_avail = '0;
    sample();
    chk("full_ok", dispatch_ok, 0);
    chk("full_sel", dispatch_sel, 0);
    tick();

    // Stall, then flush with everything ready
    clr(); wake(1, 0); fu_stall[0] = 1;
    sample(); chk("stall_issue_en", issue_en, 0); tick();
    clr(); rs_avail = 8'hFF; dispatch_req = 1;
    rs_avail = 8'h0F;
    sample(); tick();
    for (int e = 0; e < NUM_RS; e++) wake(e, e % NUM_FU);
    rs_avail = 8'hFF; pipe_flush = 1;
    sample();
    chk("flush_issue_en", issue_en, 0);
    chk("flush_ok", dispatch_ok, 0);
    tick();
    clr(); rs_avail = 8'hFF; dispatch_req = 1;
    sample(); chk("flush_rr_zero", dispatch_sel, 8'h01); tick();

    // Reset mid-operation with FU3 busy
    clr(); wake(3, 3);
    sample(); tick();
    rs_issued[3] = 1'b1;
    sample(); tick();
    rs_wake_up = '1; rs_issued = '0; rs_avail = '1; dispatch_req = 1;
    rst_n = 0;
    m_busy = 0; m_rr = 0;
    #1;
    chk("mrst_issue_en", issue_en, 0);
    chk("mrst_valid", fu_issue_valid, 0);
    chk("mrst_ok", dispatch_ok, 0);
    chk("mrst_sel", dispatch_sel, 0);
    tick();
    rst_n = 1;
    clr(); wake(6, 3);
    sample();
    chk("mrst_fu3_grant", fu_issue_valid[3], 1);
    tick();

    // Randomized run against the model
    clr();
    for (int n = 0; n < 500; n++) begin
      rs_wake_up = '0;
      for (int e = 0; e < NUM_RS; e++) begin
        if ($urandom_range(0, 2) != 0) wake(e, $urandom_range(0, NUM_FU - 1));
        set_age(e, $urandom_range(0, AGE_MOD - 1));
        rs_issued[e] = ($urandom_range(0, 3) == 0);
        fu_stall[e % NUM_FU] = ($urandom_range(0, 3) == 0);
      end
      rob_head     = AGE_W'($urandom_range(0, AGE_MOD - 1));
      rs_avail     = ($urandom_range(0, 7) == 0) ? '0 : NUM_RS'($urandom);
      pipe_flush   = ($urandom_range(0, 15) == 0);
      dispatch_req = $urandom_range(0, 1);
      sample();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
Scheduler for a bank of single-entry reservation stations. Each cycle, for every FU, it selects the oldest woken, un-issued entry targeting that FU and drives that entry's issue_en. It also allocates a free entry for the incoming dispatch packet using a round-robin pointer. It holds an occupancy counter for the one non-pipelined FU, and sits between dispatch, the RS bank and the FU issue ports.

Parameters:
NUM_RS, 8, number of RS entries (power of 2, >=2)
NUM_FU, 4, number of FUs / issue ports (matches writeback/issue width)
AGE_W, 6, width of rs_age and rob_head (ROB index plus wrap bit)
MULTI_FU_ID, 3, index of the non-pipelined FU
MULTI_LAT, 4, occupancy cycles of FU MULTI_FU_ID per issue (1 = pipelined)

Ports:
clk  in  1  clock
rst_n  in  1  reset
pipe_flush  in  1  squash; no issue/dispatch this cycle, internal state cleared
rs_wake_up  in  NUM_RS*NUM_FU  entry e bits [e*NUM_FU +: NUM_FU], one-hot FU the entry is ready for, or 0
rs_issued  in  NUM_RS  entry already issued, masked from select
rs_avail  in  NUM_RS  entry free for dispatch
rs_age  in  NUM_RS*AGE_W  entry e ROB tag at [e*AGE_W +: AGE_W]
rob_head  in  AGE_W  ROB head tag, oldest reference
fu_stall  in  NUM_FU  FU cannot accept an instruction this cycle
dispatch_req  in  1  dispatch stage has a valid packet for this bank
issue_en  out  NUM_RS  per-entry issue grant, to RS issue_en
fu_issue_valid  out  NUM_FU  FU f receives an instruction this cycle
fu_issue_idx  out  NUM_FU*$clog2(NUM_RS)  granted entry index per FU
dispatch_sel  out  NUM_RS  one-hot entry that receives the dispatch packet (gates packet_valid)
dispatch_ok  out  1  a free entry exists; dispatch_req is accepted

Behaviour:
- Reset is asynchronous and active-low: rst_n low clears the internal state (busy_cnt=0, rr_ptr=0). While rst_n is low, all outputs are forced 0.
- Outputs are combinational from inputs and registered state, giving zero-cycle grant latency. The RS frees the entry on the same clock edge.
- Eligibility: entry e is eligible for FU f when all of these hold: rs_wake_up[e][f]=1, rs_issued[e]=0, fu_stall[f]=0, pipe_flush=0, and FU f is not MULTI_FU_ID with busy_cnt!=0.
- Age: rel_e = (rs_age[e] - rob_head) mod 2^AGE_W, unsigned. Smaller rel is older. On equal rel, the lower index wins. This handles ROB wrap-around.
- Per FU, grant the single eligible entry with minimum rel.
  - fu_issue_valid[f]=1 and fu_issue_idx[f]=the winner's index; fu_issue_idx=0 when no winner.
  - issue_en[e] = OR over all FUs of grant(e,f). At most one FU per entry, since wake_up is one-hot.
- Multi-cycle FU:
  - A grant on MULTI_FU_ID with MULTI_LAT>1 loads busy_cnt <= MULTI_LAT-1.
  - When busy_cnt!=0, it decrements by 1 per cycle, and no grant is given to that FU.
  - pipe_flush clears busy_cnt to 0.
- Dispatch allocation:
  - Scan rs_avail circularly starting at rr_ptr; dispatch_sel = the first set bit.
  - dispatch_ok = |rs_avail & ~pipe_flush.
  - dispatch_sel is driven only when dispatch_req & dispatch_ok; otherwise it is 0.
  - On an accepted dispatch, rr_ptr <= (sel_idx+1) mod NUM_RS; otherwise rr_ptr holds.
  - pipe_flush sets rr_ptr <= 0.
- Full: rs_avail=0 gives dispatch_ok=0 and dispatch_sel=0; the dispatch stage must stall.
- An entry being issued this cycle is never avail, so issue and dispatch never target the same entry. An entry freed this cycle becomes avail the next cycle.
- Flush takes priority over all grants. issue_en=0 in the flush cycle.

Optional Feature:
RS_SCHED_PERF_EN: adds outputs perf_issue_cnt[NUM_FU*32] and perf_full_cnt[32]. These are free-running counters, reset to 0 by rst_n only and unaffected by pipe_flush. perf_issue_cnt[f] increments on each fu_issue_valid[f]. perf_full_cnt increments when dispatch_req & ~dispatch_ok. Without the macro these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Age select with wrap: rob_head=60. Entries 2 (age 62) and 5 (age 1) both woken for FU0 -> issue_en=8'b0000_0100, fu_issue_idx[0]=2. Next cycle, with entry 2 now unavailable/unwoken -> entry 5 granted.
- Parallel FUs: entry 0 ready for FU1, entry 7 ready for FU2 -> issue_en=8'b1000_0001 in the same cycle; fu_issue_valid=4'b0110.
- Multi-cycle FU: entries 3 and 4 both ready for FU3 with MULTI_LAT=4 -> entry 3 granted at cycle t, no FU3 grant at t+1..t+3, entry 4 granted at t+4. Repeat with a flush at t+1 -> a grant is possible at t+2 (flush cycle itself has no grant).
- Dispatch round-robin/full: rs_avail=8'hFF, 3 consecutive dispatch_req -> dispatch_sel=1,2,4 in order. Then rs_avail=0 -> dispatch_ok=0, dispatch_sel=0.
- Stall/flush: fu_stall[0]=1 with an entry ready for FU0 -> issue_en=0. pipe_flush=1 with all entries ready -> issue_en=0, dispatch_ok=0, rr_ptr returns to 0.
- Reset mid-operation: assert rst_n low while busy_cnt=2 -> all outputs immediately 0. After release, an FU3 grant is available in the first cycle.
